// File: rtl/axi_s2mm_pkg.sv
// rtl/axi_s2mm_pkg.sv - shared types, AXI constants and 4 KB boundary helper for the S2MM burst writer
//
// Contents:
//   state_e            : control FSM states (IDLE, ADDR, DATA, RESP, DONE)
//   AXI_BURST_INCR     : awburst encoding for incrementing bursts
//   AXI_RESP_OKAY      : bresp value treated as success
//   AXI_CACHE_DEFAULT  : awcache (bufferable, modifiable)
//   AXI_PROT_DEFAULT   : awprot (unprivileged, secure, data)
//   beats_to_4k()      : beats remaining before the next 4 KB address boundary

package axi_s2mm_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

  // addr_low is the byte offset inside the current 4 KB page; the address is
  // beat-aligned, so the result is always at least 1.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_low,
                                              input int          size_log2);
    logic [12:0] bytes_left;
    bytes_left = 13'h1000 - {1'b0, addr_low};
    return bytes_left >> size_log2;
  endfunction

endpackage

// File: rtl/axi_s2mm_burst_calc.sv
// rtl/axi_s2mm_burst_calc.sv - combinational burst length selection (min of remaining, MAX_BURST, 4 KB room)
//
// Parameters:
//   DATA_W, LEN_W, MAX_BURST : as in the top module
//   SPLIT_EN                 : 1 = never let a burst cross a 4 KB boundary
// Ports:
//   i_addr_low   : low 12 bits of the current beat-aligned burst address
//   i_remaining  : beats still to be written for the command
//   o_burst      : beats in the next burst (1..MAX_BURST while i_remaining > 0)

module axi_s2mm_burst_calc
  import axi_s2mm_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 23,
  parameter int MAX_BURST = 16,
  parameter bit SPLIT_EN  = 1'b0
) (
  input  logic [11:0]      i_addr_low,
  input  logic [LEN_W-1:0] i_remaining,
  output logic [8:0]       o_burst
);

  localparam int SIZE_LOG2 = $clog2(DATA_W / 8);

  logic [LEN_W-1:0] max_term;
  logic [LEN_W-1:0] page_term;
  logic [LEN_W-1:0] bound_term;
  logic [LEN_W-1:0] lim;

  always_comb begin
    max_term   = LEN_W'(MAX_BURST);
    page_term  = LEN_W'(beats_to_4k(i_addr_low, SIZE_LOG2));
    // Without the split the page term simply collapses onto MAX_BURST.
    bound_term = SPLIT_EN ? page_term : max_term;
    lim        = i_remaining;
    if (max_term < lim) begin
      lim = max_term;
    end
    if (bound_term < lim) begin
      lim = bound_term;
    end
    o_burst = 9'(lim);
  end

endmodule

// File: rtl/axi_s2mm_burst_writer.sv
// rtl/axi_s2mm_burst_writer.sv - stream-to-memory-mapped AXI4 burst writer, one burst in flight
//
// Optional feature macro: S2MM_4K_SPLIT_EN (defined = split bursts at 4 KB boundaries).
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   i_wr_cmd_addr/length/req     : command (start byte address, byte length, request)
//   o_wr_cmd_ack                 : 1-cycle pulse when a command is accepted
//   i_wr_valid/i_wr_data/o_wr_ready : write data stream, passed through to the W channel
//   o_write_finish/o_write_error : 1-cycle completion pulse, error qualifier (any non-OKAY bresp)
//   hp_aw*, hp_w*, hp_b*         : AXI4 write address, write data and write response channels

module axi_s2mm_burst_writer
  import axi_s2mm_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 23,
  parameter int MAX_BURST = 16,
  parameter int AXI_ID    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     i_wr_cmd_addr,
  input  logic [LEN_W-1:0]      i_wr_cmd_length,
  input  logic                  i_wr_cmd_req,
  output logic                  o_wr_cmd_ack,
  input  logic                  i_wr_valid,
  input  logic [DATA_W-1:0]     i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_write_finish,
  output logic                  o_write_error,
  output logic                  hp_awvalid,
  input  logic                  hp_awready,
  output logic [3:0]            hp_awid,
  output logic [ADDR_W-1:0]     hp_awaddr,
  output logic [7:0]            hp_awlen,
  output logic [2:0]            hp_awsize,
  output logic [1:0]            hp_awburst,
  output logic [2:0]            hp_awprot,
  output logic [3:0]            hp_awcache,
  output logic [DATA_W-1:0]     hp_wdata,
  output logic [DATA_W/8-1:0]   hp_wstrb,
  output logic                  hp_wlast,
  output logic                  hp_wvalid,
  input  logic                  hp_wready,
  input  logic [1:0]            hp_bresp,
  input  logic                  hp_bvalid,
  output logic                  hp_bready
);

  localparam int BPB       = DATA_W / 8;
  localparam int SIZE_LOG2 = $clog2(BPB);

`ifdef S2MM_4K_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [8:0]        burst_q, burst_d;
  logic [8:0]        beat_q, beat_d;
  logic              err_q, err_d;
  logic              ack_q, ack_d;
  logic              finish_q, finish_d;
  logic              error_q, error_d;

  logic [8:0]        calc_burst;
  logic [LEN_W-1:0]  cmd_beats;
  logic [LEN_W-1:0]  rem_after;
  logic              in_addr, in_data, in_resp;
  logic              last_beat;

  axi_s2mm_burst_calc #(
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .MAX_BURST (MAX_BURST),
    .SPLIT_EN  (SPLIT_EN)
  ) u_burst_calc (
    .i_addr_low  (addr_q[11:0]),
    .i_remaining (remaining_q),
    .o_burst     (calc_burst)
  );

  // Trailing bytes that do not fill a whole beat are dropped.
  assign cmd_beats = i_wr_cmd_length >> SIZE_LOG2;

  assign in_addr   = (state_q == ADDR);
  assign in_data   = (state_q == DATA);
  assign in_resp   = (state_q == RESP);
  assign last_beat = (beat_q == burst_q - 9'd1);

  // AW fields come straight from registers that do not change while in ADDR,
  // so they stay stable for the whole handshake.
  assign hp_awvalid = in_addr;
  assign hp_awid    = in_addr ? 4'(AXI_ID) : 4'd0;
  assign hp_awaddr  = in_addr ? addr_q : '0;
  assign hp_awlen   = in_addr ? 8'(calc_burst - 9'd1) : 8'd0;
  assign hp_awsize  = in_addr ? 3'(SIZE_LOG2) : 3'd0;
  assign hp_awburst = in_addr ? AXI_BURST_INCR : 2'b00;
  assign hp_awcache = in_addr ? AXI_CACHE_DEFAULT : 4'd0;
  assign hp_awprot  = in_addr ? AXI_PROT_DEFAULT : 3'd0;

  // W channel is a zero-latency pass-through of the input stream during DATA.
  assign hp_wvalid  = in_data & i_wr_valid;
  assign o_wr_ready = in_data & hp_wready;
  assign hp_wdata   = in_data ? i_wr_data : '0;
  assign hp_wstrb   = in_data ? '1 : '0;
  assign hp_wlast   = in_data & last_beat;

  assign hp_bready  = in_resp;

  assign o_wr_cmd_ack   = ack_q;
  assign o_write_finish = finish_q;
  assign o_write_error  = error_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    beat_d      = beat_q;
    err_d       = err_q;
    ack_d       = 1'b0;
    finish_d    = 1'b0;
    error_d     = 1'b0;
    rem_after   = remaining_q - LEN_W'(burst_q);

    unique case (state_q)
      IDLE: begin
        if (i_wr_cmd_req) begin
          addr_d      = i_wr_cmd_addr & ~ADDR_W'(BPB - 1);
          remaining_d = cmd_beats;
          burst_d     = 9'd0;
          beat_d      = 9'd0;
          ack_d       = 1'b1;
          state_d     = (cmd_beats == '0) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (hp_awready) begin
          burst_d = calc_burst;
          beat_d  = 9'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (hp_wvalid && hp_wready) begin
          if (last_beat) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + 9'd1;
          end
        end
      end
      RESP: begin
        if (hp_bvalid) begin
          err_d       = err_q | (hp_bresp != AXI_RESP_OKAY);
          addr_d      = addr_q + (ADDR_W'(burst_q) << SIZE_LOG2);
          remaining_d = rem_after;
          state_d     = (rem_after != '0) ? ADDR : DONE;
        end
      end
      DONE: begin
        finish_d = 1'b1;
        error_d  = err_q;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_q     <= 9'd0;
      beat_q      <= 9'd0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
      finish_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      finish_q    <= finish_d;
      error_q     <= error_d;
    end
  end

endmodule

// File: tb/tb_axi_s2mm_burst_writer.sv
// tb/tb_axi_s2mm_burst_writer.sv - randomized self-checking bench with AXI RAM responder and burst model

module tb_axi_s2mm_burst_writer;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 23;
  localparam int MAX_BURST = 16;

  logic              clk, rst;
  logic [ADDR_W-1:0] i_wr_cmd_addr;
  logic [LEN_W-1:0]  i_wr_cmd_length;
  logic              i_wr_cmd_req, o_wr_cmd_ack;
  logic              i_wr_valid, o_wr_ready;
  logic [DATA_W-1:0] i_wr_data;
  logic              o_write_finish, o_write_error;
  logic              hp_awvalid, hp_awready;
  logic [3:0]        hp_awid;
  logic [ADDR_W-1:0] hp_awaddr;
  logic [7:0]        hp_awlen;
  logic [2:0]        hp_awsize, hp_awprot;
  logic [1:0]        hp_awburst;
  logic [3:0]        hp_awcache;
  logic [DATA_W-1:0] hp_wdata;
  logic [7:0]        hp_wstrb;
  logic              hp_wlast, hp_wvalid, hp_wready;
  logic [1:0]        hp_bresp;
  logic              hp_bvalid, hp_bready;

  axi_s2mm_burst_writer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .i_wr_cmd_addr(i_wr_cmd_addr), .i_wr_cmd_length(i_wr_cmd_length),
    .i_wr_cmd_req(i_wr_cmd_req), .o_wr_cmd_ack(o_wr_cmd_ack),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .o_write_finish(o_write_finish), .o_write_error(o_write_error),
    .hp_awvalid(hp_awvalid), .hp_awready(hp_awready), .hp_awid(hp_awid),
    .hp_awaddr(hp_awaddr), .hp_awlen(hp_awlen), .hp_awsize(hp_awsize),
    .hp_awburst(hp_awburst), .hp_awprot(hp_awprot), .hp_awcache(hp_awcache),
    .hp_wdata(hp_wdata), .hp_wstrb(hp_wstrb), .hp_wlast(hp_wlast),
    .hp_wvalid(hp_wvalid), .hp_wready(hp_wready),
    .hp_bresp(hp_bresp), .hp_bvalid(hp_bvalid), .hp_bready(hp_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Responder / source / monitor state
  logic [63:0] mem [logic [31:0]];
  logic [63:0] src_q [$];
  int          src_pos;
  logic [31:0] aw_addr_log [$];
  logic [7:0]  aw_len_log [$];
  logic [31:0] exp_a [$];
  logic [7:0]  exp_l [$];
  logic [31:0] w_addr, held_addr;
  logic [7:0]  held_len;
  logic [31:0] err_mask;
  logic [31:0] cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  int  w_left, b_wait, b_idx, wbeats, wlast_bad;
  int  ack_cnt, fin_cnt, ack_at, fin_at, req_cyc, cyc;
  bit  fin_err, aw_hold, junk_en;
  int  stab_bad = 0, const_bad = 0, pass_bad = 0;

  task automatic resp_reset();
    b_wait  = -1;
    w_left  = 0;
    aw_hold = 1'b0;
    junk_en = 1'b0;
  endtask

  // One clock: drive at the falling edge, sample just before the rising edge.
  task automatic step(input bit req);
    @(negedge clk);
    cyc++;
    hp_awready = ($urandom_range(0, 3) != 0);
    hp_wready  = ($urandom_range(0, 3) != 0);
    if (src_pos < src_q.size()) begin
      i_wr_valid = ($urandom_range(0, 3) != 0);
      i_wr_data  = src_q[src_pos];
    end else begin
      i_wr_valid = 1'b0;
      i_wr_data  = {$urandom, $urandom};
    end
    hp_bvalid = (b_wait == 0);
    hp_bresp  = (b_wait == 0 && b_idx < 32 && err_mask[b_idx]) ? 2'b10 : 2'b00;
    if (b_wait > 0) b_wait--;
    if (req) begin
      i_wr_cmd_req    = 1'b1;
      i_wr_cmd_addr   = cmd_addr;
      i_wr_cmd_length = cmd_len;
    end else if (junk_en && b_idx < exp_a.size()) begin
      i_wr_cmd_req    = 1'($urandom_range(0, 1));
      i_wr_cmd_addr   = $urandom;
      i_wr_cmd_length = LEN_W'($urandom);
    end else begin
      i_wr_cmd_req = 1'b0;
    end
    #4;
    if (hp_awvalid) begin
      if (aw_hold && (hp_awaddr !== held_addr || hp_awlen !== held_len)) stab_bad++;
      if (hp_awsize !== 3'd3 || hp_awburst !== 2'b01 || hp_awcache !== 4'b0011 ||
          hp_awprot !== 3'b000 || hp_awid !== 4'd0) const_bad++;
      if (hp_awready) begin
        aw_addr_log.push_back(hp_awaddr);
        aw_len_log.push_back(hp_awlen);
        w_addr  = hp_awaddr;
        w_left  = int'(hp_awlen) + 1;
        aw_hold = 1'b0;
      end else begin
        aw_hold   = 1'b1;
        held_addr = hp_awaddr;
        held_len  = hp_awlen;
      end
    end else begin
      aw_hold = 1'b0;
    end
    if ((hp_wvalid && hp_wready) !== (i_wr_valid && o_wr_ready)) pass_bad++;
    if (hp_wvalid && hp_wready) begin
      if (hp_wdata !== i_wr_data || hp_wstrb !== 8'hFF) pass_bad++;
      mem[w_addr >> 3] = hp_wdata;
      w_addr = w_addr + 32'd8;
      wbeats++;
      src_pos++;
      w_left--;
      if (hp_wlast !== (w_left == 0)) wlast_bad++;
      if (w_left == 0) b_wait = $urandom_range(0, 3);
    end
    if (hp_bvalid && hp_bready) begin
      b_idx++;
      b_wait = -1;
    end
    if (o_wr_cmd_ack) begin ack_cnt++; ack_at = cyc; end
    if (o_write_finish) begin fin_cnt++; fin_at = cyc; fin_err = o_write_error; end
  endtask

  // Reference: split the command into bursts from the block's rules alone.
  task automatic start_cmd(input logic [31:0] addr, input int len, input logic [31:0] mask);
    logic [31:0] a;
    int rem, n, room;
    exp_a.delete(); exp_l.delete();
    aw_addr_log.delete(); aw_len_log.delete();
    src_q.delete(); mem.delete();
    a   = addr & ~32'h7;
    rem = len / 8;
    while (rem > 0) begin
      n = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef S2MM_4K_SPLIT_EN
      room = (4096 - int'(a % 32'd4096)) / 8;
      if (room < n) n = room;
`else
      room = n;
`endif
      exp_a.push_back(a);
      exp_l.push_back(8'(n - 1));
      a   = a + 32'(n * 8);
      rem = rem - n;
    end
    for (int i = 0; i < len / 8; i++) src_q.push_back({$urandom, $urandom});
    src_pos = 0; b_idx = 0; wbeats = 0; wlast_bad = 0;
    ack_cnt = 0; fin_cnt = 0; ack_at = -1; fin_at = -1; fin_err = 1'b0;
    err_mask = mask; cmd_addr = addr; cmd_len = LEN_W'(len);
    req_cyc = cyc + 1;
    step(1'b1);
    junk_en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; i_wr_cmd_req = 1'b0; i_wr_valid = 1'b0; hp_bvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    resp_reset();
  endtask

  task automatic finish_cmd(input string tag);
    int n, bad;
    bit exp_err;
    logic [31:0] k;
    n = 0;
    while (fin_cnt == 0 && n < 3000) begin step(1'b0); n++; end
    junk_en = 1'b0;
    if (fin_cnt == 0) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
      do_reset();
    end else begin
      repeat (3) step(1'b0);
    end
    exp_err = 1'b0;
    for (int i = 0; i < exp_a.size(); i++) if (i < 32 && err_mask[i]) exp_err = 1'b1;
    check_eq({tag, "_ack_cnt"}, 64'(ack_cnt), 64'd1);
    check_eq({tag, "_ack_lat"}, 64'(ack_at - req_cyc), 64'd1);
    check_eq({tag, "_fin_cnt"}, 64'(fin_cnt), 64'd1);
    check_eq({tag, "_fin_err"}, 64'(fin_err), 64'(exp_err));
    if (exp_a.size() == 0) check_eq({tag, "_fin_lat"}, 64'(fin_at - req_cyc), 64'd2);
    check_eq({tag, "_aw_cnt"}, 64'(aw_addr_log.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < aw_addr_log.size(); i++) begin
      check_eq($sformatf("%s_awaddr%0d", tag, i), 64'(aw_addr_log[i]), 64'(exp_a[i]));
      check_eq($sformatf("%s_awlen%0d", tag, i), 64'(aw_len_log[i]), 64'(exp_l[i]));
    end
    check_eq({tag, "_w_beats"}, 64'(wbeats), 64'(src_q.size()));
    check_eq({tag, "_wlast"}, 64'(wlast_bad), 64'd0);
    bad = 0;
    for (int i = 0; i < src_q.size(); i++) begin
      k = ((cmd_addr & ~32'h7) + 32'(8 * i)) >> 3;
      if (!mem.exists(k)) bad++;
      else if (mem[k] !== src_q[i]) bad++;
    end
    check_eq({tag, "_ram"}, 64'(bad), 64'd0);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] addr, input int len,
                         input logic [31:0] mask);
    start_cmd(addr, len, mask);
    finish_cmd(tag);
  endtask

  task automatic check_zero(input string tag);
    logic [39:0] ctl;
    ctl = {hp_awvalid, hp_awlen, hp_awsize, hp_awburst, hp_awcache, hp_awprot, hp_awid,
           hp_wvalid, hp_wstrb, hp_wlast, hp_bready, o_wr_ready, o_wr_cmd_ack,
           o_write_finish, o_write_error};
    check_eq({tag, "_ctl"}, 64'(ctl), 64'd0);
    check_eq({tag, "_awaddr"}, 64'(hp_awaddr), 64'd0);
    check_eq({tag, "_wdata"}, hp_wdata, 64'd0);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    cyc = 0; err_mask = '0; b_idx = 0;
    resp_reset();
    rst = 1'b1; i_wr_cmd_req = 1'b0; i_wr_cmd_addr = '0; i_wr_cmd_length = '0;
    i_wr_valid = 1'b1; i_wr_data = 64'hDEAD_BEEF_0123_4567;
    hp_awready = 1'b1; hp_wready = 1'b1; hp_bvalid = 1'b0; hp_bresp = 2'b00;
    repeat (3) @(negedge clk);
    #4;
    check_zero("rst_init");
    @(negedge clk);
    rst = 1'b0; i_wr_valid = 1'b0;

    run_cmd("single", 32'h0, 16, 32'h0);
    run_cmd("two_bursts", 32'h0, 256, 32'h0);
    run_cmd("page_cross", 32'hFC0, 128, 32'h0);
    run_cmd("len0", 32'h40, 0, 32'h0);
    run_cmd("len7", 32'h48, 7, 32'h0);
    run_cmd("slverr", 32'h0, 256, 32'h1);
    run_cmd("after_err", 32'h2000, 128, 32'h0);

    // Reset in the middle of the data phase
    start_cmd(32'h0, 256, 32'h0);
    n = 0;
    while (wbeats < 3 && n < 500) begin step(1'b0); n++; end
    check_eq("mid_reached", 64'(wbeats >= 3), 64'd1);
    @(negedge clk);
    rst = 1'b1; i_wr_cmd_req = 1'b0; i_wr_valid = 1'b0;
    hp_wready = 1'b1; hp_awready = 1'b0; hp_bvalid = 1'b0;
    @(negedge clk);
    i_wr_valid = 1'b1; i_wr_data = 64'hA5A5_5A5A_F0F0_0F0F;
    #4;
    check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0; i_wr_valid = 1'b0;
    resp_reset();
    run_cmd("post_rst", 32'h100, 64, 32'h0);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = ($urandom & 32'hFFFF_F000) | 32'hF80 | ($urandom & 32'h7F);
        default: a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
      endcase
      run_cmd($sformatf("rnd%0d", t), a, $urandom_range(0, 400),
              ($urandom_range(0, 3) == 0) ? $urandom : 32'h0);
    end

    check_eq("aw_stable", 64'(stab_bad), 64'd0);
    check_eq("aw_const", 64'(const_bad), 64'd0);
    check_eq("w_passthru", 64'(pass_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_s2mm_burst_writer.md
AXI_S2MM_BURST_WRITER -- requirements
Module: axi_s2mm_burst_writer

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- DATA_W, 64, stream and AXI data width in bits (power of 2, 32..256).
- ADDR_W, 32, AXI address width.
- LEN_W, 23, command byte-length width.
- MAX_BURST, 16, maximum beats per burst (1..256).
- AXI_ID, 0, constant awid value.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is on its rising edge.
- rst, in, 1, reset, synchronous and active-high.
- i_wr_cmd_addr, in, ADDR_W, start byte address.
- i_wr_cmd_length, in, LEN_W, transfer length in bytes.
- i_wr_cmd_req, in, 1, command request.
- o_wr_cmd_ack, out, 1, command accepted (1-cycle pulse).
- i_wr_valid / i_wr_data / o_wr_ready, in / in / out, 1 / DATA_W / 1, write data stream.
- o_write_finish, out, 1, transfer complete (1-cycle pulse).
- o_write_error, out, 1, qualifies o_write_finish: at least one non-OKAY bresp occurred.
- hp_aw{valid,ready,id,addr,len,size,burst,prot,cache}: AXI4 AW channel; len is 8 bits, id is 4 bits.
- hp_w{data,strb,last,valid,ready}: AXI4 W channel.
- hp_b{resp,valid,ready}: AXI4 B channel.

Function
REQ-003 The block SHALL use states IDLE, ADDR, DATA, RESP, DONE.
REQ-004 In IDLE with i_wr_cmd_req=1, the block SHALL latch the address (low log2(DATA_W/8) bits forced to 0) and beats = length/(DATA_W/8) (remainder bytes dropped), pulse o_wr_cmd_ack for 1 cycle, then go to ADDR; if beats=0 it SHALL go to DONE instead.
REQ-005 In ADDR the block SHALL compute burst = min(remaining beats, MAX_BURST, beats to the next 4 KB boundary when split is enabled).
REQ-006 In ADDR the block SHALL hold hp_awvalid=1 with all AW fields stable until hp_awready=1, then go to DATA; hp_awlen = burst-1.
REQ-007 AW constants SHALL be: awsize=log2(DATA_W/8), awburst=INCR (2'b01), awcache=4'b0011, awprot=3'b000, awid=AXI_ID.
REQ-008 In DATA, hp_wvalid SHALL equal i_wr_valid and o_wr_ready SHALL equal hp_wready (combinational pass-through); hp_wdata SHALL equal i_wr_data; hp_wstrb SHALL be all ones.
REQ-009 A beat counter SHALL increment on hp_wvalid&hp_wready; hp_wlast=1 on beat burst-1; after the last beat the block SHALL go to RESP.
REQ-010 Outside DATA, o_wr_ready and hp_wvalid SHALL be 0.
REQ-011 In RESP, hp_bready SHALL be 1; on hp_bvalid the block SHALL OR (hp_bresp!=2'b00) into a sticky error flag, add burst*(DATA_W/8) to the address, subtract burst from remaining, and go to ADDR if remaining>0, else to DONE.
REQ-012 DONE SHALL last 1 cycle, pulse o_write_finish with o_write_error = sticky flag, clear the flag, and return to IDLE.
REQ-013 At most one burst SHALL be outstanding; i_wr_cmd_req SHALL be ignored outside IDLE.
REQ-014 Address arithmetic SHALL be ADDR_W wide and wrap modulo 2^ADDR_W.

Reset
REQ-015 rst SHALL force IDLE and set every output to 0, clearing counters and the error flag; an in-flight burst is abandoned without completion pulses.

Configuration
REQ-016 With S2MM_4K_SPLIT_EN defined, no burst SHALL cross a 4 KB boundary; without it, bursts SHALL be limited only by MAX_BURST and remaining beats.

Structure
REQ-017 Package axi_s2mm_pkg SHALL hold the state enum, AXI_BURST_INCR, AXI_RESP_OKAY, AXI_CACHE_DEFAULT, and a function giving beats to the 4 KB boundary.
REQ-018 Burst-size selection SHALL be the sub-module axi_s2mm_burst_calc (combinational min of 3 terms); everything else SHALL be in the top module.

Verification (DATA_W=64, MAX_BURST=16, split enabled, responder is an AXI RAM model)
REQ-019 addr 0x0, length 16 -> one AW with awlen=1; 2 W beats, wlast on the 2nd; finish=1, error=0; RAM holds the data.
REQ-020 addr 0x0, length 256 -> 2 bursts: 0x000 with awlen=15, then 0x080 with awlen=15; exactly one finish pulse.
REQ-021 addr 0xFC0, length 128 -> bursts at 0xFC0 (awlen=7) and 0x1000 (awlen=7); with the macro undefined, one burst (awlen=15).
REQ-022 length 0 (and length 7) -> ack, then finish 2 cycles later; no AW or W activity.
REQ-023 Responder returns SLVERR on the 1st of 2 bursts -> both bursts complete; finish with error=1; the next command finishes with error=0.
REQ-024 rst asserted mid-DATA with i_wr_valid toggling -> next cycle all outputs are 0 and the state is IDLE; a new command then completes normally.
